sysid_checker: RTL



---
 rtl/sysid_checker.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : sysid_checker
// Brief    : Avalon-MM master that reads the system-ID and build-timestamp
//            words and compares them against the expected image identity.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd40899754,
    parameter logic [31:0] EXPECTED_TS    = 32'd1242736836,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_word,
    output logic [31:0] ts_word
);

    localparam logic [15:0] c_TIMEOUT_LOAD = TIMEOUT_CYCLES[15:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_ID  = 2'd1,
        S_RD_TS  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_auto;
    logic [15:0] r_cnt;
    logic        r_pass;
    logic        r_id_mm;
    logic        r_ts_mm;
    logic        r_timeout;
    logic [31:0] r_id_word;
    logic [31:0] r_ts_word;
    logic        w_start_check;
    logic        w_reading;
    logic        w_accept;
    logic        w_expired;
    logic        w_ts_mm_now;

    assign w_reading   = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_accept    = w_reading && !avm_waitrequest;
    assign w_expired   = w_reading && avm_waitrequest && (r_cnt == 16'd0);
    assign w_ts_mm_now = (avm_readdata != EXPECTED_TS);

    always_comb begin
        w_next        = r_state;
        w_start_check = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_auto || start) begin
                    w_next        = S_RD_ID;
                    w_start_check = 1'b1;
                end
            end
            S_RD_ID: begin
                if (!avm_waitrequest) begin
                    w_next = S_RD_TS;
                end else if (r_cnt == 16'd0) begin
                    w_next = S_FINISH;
                end
            end
            S_RD_TS: begin
                if (!avm_waitrequest || (r_cnt == 16'd0)) begin
                    w_next = S_FINISH;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_auto    <= AUTO_START;
            r_cnt     <= 16'd0;
            r_pass    <= 1'b0;
            r_id_mm   <= 1'b0;
            r_ts_mm   <= 1'b0;
            r_timeout <= 1'b0;
            r_id_word <= 32'd0;
            r_ts_word <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_start_check) begin
                r_auto    <= 1'b0;
                r_cnt     <= c_TIMEOUT_LOAD;
                r_pass    <= 1'b0;
                r_id_mm   <= 1'b0;
                r_ts_mm   <= 1'b0;
                r_timeout <= 1'b0;
                r_id_word <= 32'd0;
                r_ts_word <= 32'd0;
            end else if (w_accept) begin
                r_cnt <= c_TIMEOUT_LOAD;
                if (r_state == S_RD_ID) begin
                    r_id_word <= avm_readdata;
                    r_id_mm   <= (avm_readdata != EXPECTED_ID);
                end else begin
                    r_ts_word <= avm_readdata;
                    r_ts_mm   <= w_ts_mm_now;
                    // Verdict is formed here so it is already valid in the FINISH cycle.
                    r_pass    <= !r_id_mm && !(CHECK_TS && w_ts_mm_now);
                end
            end else if (w_expired) begin
                r_timeout <= 1'b1;
            end else if (w_reading) begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign avm_read    = w_reading;
    assign avm_address = (r_state == S_RD_TS);
    assign busy        = w_reading;
    assign done        = (r_state == S_FINISH);
    assign pass        = r_pass;
    assign id_mismatch = r_id_mm;
    assign ts_mismatch = r_ts_mm;
    assign timeout     = r_timeout;
    assign id_word     = r_id_word;
    assign ts_word     = r_ts_word;

endmodule
`default_nettype wire
